// File: rtl/ahb_pkg.sv
// Shared AHB encodings, arbiter state type and burst-length helper.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;
   localparam logic [2:0] HBURST_INCR   = 3'd1;
   localparam logic [2:0] HBURST_WRAP4  = 3'd2;
   localparam logic [2:0] HBURST_INCR4  = 3'd3;
   localparam logic [2:0] HBURST_WRAP8  = 3'd4;
   localparam logic [2:0] HBURST_INCR8  = 3'd5;
   localparam logic [2:0] HBURST_WRAP16 = 3'd6;
   localparam logic [2:0] HBURST_INCR16 = 3'd7;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_OWN    = 2'd1,
      ARB_BURST  = 2'd2,
      ARB_LOCKED = 2'd3
   } arb_state_e;

   // Beats remaining after the NONSEQ beat; 0 means undefined-length or single.
   function automatic logic [3:0] burst_beats(input logic [2:0] burst);
      case (burst)
         HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
         HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
         HBURST_WRAP16, HBURST_INCR16: return 4'd15;
         default:                      return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_arb_sel.sv
// Combinational master selector: fixed lowest-index priority, or rotating
// priority after the last owner when AHB_ARB_ROUND_ROBIN_EN is defined.
module ahb_arb_sel #(
   parameter int MASTER_NUM = 4,
   parameter int MID_WIDTH  = 3
) (
   input  logic [MASTER_NUM-1:0] busreq_i,
`ifdef AHB_ARB_ROUND_ROBIN_EN
   input  logic [MID_WIDTH-1:0]  ptr_i,
`endif
   output logic [MASTER_NUM-1:0] grant_o,
   output logic [MID_WIDTH-1:0]  idx_o,
   output logic                  valid_o
);

`ifdef AHB_ARB_ROUND_ROBIN_EN
   int best_dist;
   int dist;

   // Distance from ptr+1; the last owner itself is the furthest candidate.
   always_comb begin
      grant_o   = '0;
      idx_o     = '0;
      valid_o   = |busreq_i;
      best_dist = MASTER_NUM;
      dist      = 0;
      for (int j = 0; j < MASTER_NUM; j++) begin
         dist = (j + 2 * MASTER_NUM - int'(ptr_i) - 1) % MASTER_NUM;
         if (busreq_i[j] && (dist < best_dist)) begin
            best_dist  = dist;
            idx_o      = MID_WIDTH'(j);
            grant_o    = '0;
            grant_o[j] = 1'b1;
         end
      end
   end
`else
   // Scan downwards so the lowest requesting index is written last.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = MASTER_NUM - 1; i >= 0; i--) begin
         if (busreq_i[i]) begin
            grant_o    = '0;
            grant_o[i] = 1'b1;
            idx_o      = MID_WIDTH'(i);
            valid_o    = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: grant FSM, fixed-burst counter and HMASTER/data-owner pipeline.
// Build option AHB_ARB_ROUND_ROBIN_EN selects rotating priority; arb_state_out exposes the FSM.
module ahb_arbiter
   import ahb_pkg::*;
#(
   parameter int MASTER_NUM     = 4,
   parameter int DEFAULT_MASTER = 0,
   parameter int MID_WIDTH      = 3
) (
   input  logic                  ahb_clk_in,
   input  logic                  ahb_rstn_in,
   input  logic [MASTER_NUM-1:0] master_busreq_in,
   input  logic [MASTER_NUM-1:0] master_lock_in,
   input  logic [1:0]            ahb_trans_in,
   input  logic [2:0]            ahb_burst_in,
   input  logic                  ahb_ready_in,
   output logic [MASTER_NUM-1:0] master_grant_out,
   output logic [MID_WIDTH-1:0]  ahb_master_out,
   output logic                  ahb_mastlock_out,
   output logic [MID_WIDTH-1:0]  data_master_out,
   output arb_state_e            arb_state_out
);

   localparam logic [MASTER_NUM-1:0] DEF_GRANT = MASTER_NUM'(1) << DEFAULT_MASTER;
   localparam logic [MID_WIDTH-1:0]  DEF_IDX   = MID_WIDTH'(DEFAULT_MASTER);

   arb_state_e              state_q;
   logic [MASTER_NUM-1:0]   grant_q;
   logic [MID_WIDTH-1:0]    grant_idx_q;
   logic [3:0]              cnt_q;
   logic [MID_WIDTH-1:0]    master_q;
   logic                    mastlock_q;
   logic [MID_WIDTH-1:0]    data_master_q;

   logic [MASTER_NUM-1:0]   sel_grant;
   logic [MID_WIDTH-1:0]    sel_idx;
   logic                    sel_valid;
   logic                    own_lock;
   logic                    start_burst;
   logic [3:0]              beats;

   // The granted index doubles as the last-owner pointer for rotation.
   ahb_arb_sel #(
      .MASTER_NUM (MASTER_NUM),
      .MID_WIDTH  (MID_WIDTH)
   ) u_sel (
      .busreq_i (master_busreq_in),
`ifdef AHB_ARB_ROUND_ROBIN_EN
      .ptr_i    (grant_idx_q),
`endif
      .grant_o  (sel_grant),
      .idx_o    (sel_idx),
      .valid_o  (sel_valid)
   );

   assign own_lock    = |(master_lock_in & grant_q);
   assign beats       = burst_beats(ahb_burst_in);
   assign start_burst = (ahb_trans_in == HTRANS_NONSEQ) && (beats != 4'd0);

   always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
      if (!ahb_rstn_in) begin
         state_q       <= ARB_IDLE;
         grant_q       <= DEF_GRANT;
         grant_idx_q   <= DEF_IDX;
         cnt_q         <= 4'd0;
         master_q      <= DEF_IDX;
         mastlock_q    <= 1'b0;
         data_master_q <= DEF_IDX;
      end else if (ahb_ready_in) begin
         // Address-phase owner lags the grant by one ready cycle, data phase by one more.
         master_q      <= grant_idx_q;
         mastlock_q    <= own_lock;
         data_master_q <= master_q;
         case (state_q)
            ARB_IDLE: begin
               if (sel_valid) begin
                  grant_q     <= sel_grant;
                  grant_idx_q <= sel_idx;
                  state_q     <= ARB_OWN;
               end
            end
            ARB_OWN: begin
               if (start_burst) begin
                  cnt_q   <= beats;
                  state_q <= ARB_BURST;
               end else if (own_lock) begin
                  state_q <= ARB_LOCKED;
               end else if (sel_valid) begin
                  grant_q     <= sel_grant;
                  grant_idx_q <= sel_idx;
               end else begin
                  grant_q     <= DEF_GRANT;
                  grant_idx_q <= DEF_IDX;
                  state_q     <= ARB_IDLE;
               end
            end
            ARB_BURST: begin
               if (ahb_trans_in == HTRANS_SEQ) begin
                  cnt_q <= cnt_q - 4'd1;
                  if (cnt_q <= 4'd1) begin
                     cnt_q   <= 4'd0;
                     state_q <= ARB_OWN;
                  end
               end else if (ahb_trans_in != HTRANS_BUSY) begin
                  // IDLE or a fresh NONSEQ ends the burst early.
                  cnt_q   <= 4'd0;
                  state_q <= ARB_OWN;
               end
            end
            ARB_LOCKED: begin
               if (!own_lock) begin
                  state_q <= ARB_OWN;
               end
            end
            default: begin
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

   assign master_grant_out = grant_q;
   assign ahb_master_out   = master_q;
   assign ahb_mastlock_out = mastlock_q;
   assign data_master_out  = data_master_q;
   assign arb_state_out    = state_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scenario bench for ahb_arbiter: each step pushes its expected outputs, drives one
// clock, then pops and compares; works for both priority builds.
module tb_ahb_arbiter;
   import ahb_pkg::*;

`ifdef AHB_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct packed {
      logic [3:0]  req;
      logic [3:0]  lock;
      logic [1:0]  trans;
      logic [2:0]  burst;
      logic        rdy;
      logic [12:0] exp;
   } step_t;

   logic        ahb_clk_in;
   logic        ahb_rstn_in;
   logic [3:0]  master_busreq_in;
   logic [3:0]  master_lock_in;
   logic [1:0]  ahb_trans_in;
   logic [2:0]  ahb_burst_in;
   logic        ahb_ready_in;
   logic [3:0]  master_grant_out;
   logic [2:0]  ahb_master_out;
   logic        ahb_mastlock_out;
   logic [2:0]  data_master_out;
   arb_state_e  arb_state_out;

   logic [12:0] exp_q [$];
   int          vectors;
   int          errors;

   ahb_arbiter #(
      .MASTER_NUM     (4),
      .DEFAULT_MASTER (0),
      .MID_WIDTH      (3)
   ) dut (
      .ahb_clk_in       (ahb_clk_in),
      .ahb_rstn_in      (ahb_rstn_in),
      .master_busreq_in (master_busreq_in),
      .master_lock_in   (master_lock_in),
      .ahb_trans_in     (ahb_trans_in),
      .ahb_burst_in     (ahb_burst_in),
      .ahb_ready_in     (ahb_ready_in),
      .master_grant_out (master_grant_out),
      .ahb_master_out   (ahb_master_out),
      .ahb_mastlock_out (ahb_mastlock_out),
      .data_master_out  (data_master_out),
      .arb_state_out    (arb_state_out)
   );

   // clock / reset
   initial ahb_clk_in = 1'b0;
   always #5 ahb_clk_in = ~ahb_clk_in;

   // expected word: {grant, hmaster, mastlock, data owner, state}
   function automatic logic [12:0] ex(input logic [3:0] g, input int m, input logic lk,
                                      input int d, input arb_state_e s);
      return {g, 3'(m), lk, 3'(d), 2'(s)};
   endfunction

   function automatic logic [12:0] observe();
      return {master_grant_out, ahb_master_out, ahb_mastlock_out, data_master_out, 2'(arb_state_out)};
   endfunction

   function automatic step_t mk(input logic [3:0] r, input logic [3:0] l, input logic [1:0] tr,
                                input logic [2:0] b, input logic rd, input logic [12:0] x);
      step_t s;
      s.req = r; s.lock = l; s.trans = tr; s.burst = b; s.rdy = rd; s.exp = x;
      return s;
   endfunction

   // driver: apply one cycle of inputs, sample 1 time unit after the rising edge
   task automatic drive(input step_t s);
      master_busreq_in = s.req;
      master_lock_in   = s.lock;
      ahb_trans_in     = s.trans;
      ahb_burst_in     = s.burst;
      ahb_ready_in     = s.rdy;
      @(posedge ahb_clk_in);
      #1;
   endtask

   task automatic test_reset();
      logic [12:0] want;
      logic [12:0] got;
      ahb_rstn_in = 1'b0;
      master_busreq_in = 4'b0000;
      master_lock_in = 4'b0000;
      ahb_trans_in = HTRANS_IDLE;
      ahb_burst_in = HBURST_SINGLE;
      ahb_ready_in = 1'b1;
      exp_q.push_back(ex(4'b0001, 0, 1'b0, 0, ARB_IDLE));
      repeat (2) @(posedge ahb_clk_in);
      #1;
      got = observe();
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
         errors++;
         $display("FAIL reset: got %h expected %h", got, want);
      end
      #3 ahb_rstn_in = 1'b1;
   endtask

   // Simultaneous 0110 requests, second arbitration point, then all requests drop.
   task automatic test_simultaneous();
      step_t t [6];
      logic [12:0] want;
      logic [12:0] got;
      t[0] = mk(4'b0110, 4'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b1, ex(4'b0010, 0, 1'b0, 0, ARB_OWN));
      t[1] = mk(4'b0110, 4'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b1,
                ex(RR ? 4'b0100 : 4'b0010, 1, 1'b0, 0, ARB_OWN));
      t[2] = mk(4'b0110, 4'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0,
                ex(RR ? 4'b0100 : 4'b0010, 1, 1'b0, 0, ARB_OWN));
      t[3] = mk(4'b0000, 4'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b1,
                ex(4'b0001, RR ? 2 : 1, 1'b0, 1, ARB_IDLE));
      t[4] = mk(4'b0000, 4'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b1,
                ex(4'b0001, 0, 1'b0, RR ? 2 : 1, ARB_IDLE));
      t[5] = mk(4'b0000, 4'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b1, ex(4'b0001, 0, 1'b0, 0, ARB_IDLE));
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(t[i].exp);
         drive(t[i]);
         got = observe();
         want = exp_q.pop_front();
         vectors++;
         if (got !== want) begin
            errors++;
            $display("FAIL simultaneous[%0d]: got %h expected %h", i, got, want);
         end
      end
   endtask

   // Master 1 INCR4 with BUSY and two wait states; master 2 waits for the burst end.
   task automatic test_burst();
      step_t t [13];
      logic [12:0] want;
      logic [12:0] got;
      t[0]  = mk(4'b0010, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b0010, 0, 1'b0, 0, ARB_OWN));
      t[1]  = mk(4'b0010, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b0010, 1, 1'b0, 0, ARB_OWN));
      t[2]  = mk(4'b0110, 4'b0, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, ex(4'b0010, 1, 1'b0, 1, ARB_BURST));
      t[3]  = mk(4'b0100, 4'b0, HTRANS_SEQ,    HBURST_INCR4,  1'b1, ex(4'b0010, 1, 1'b0, 1, ARB_BURST));
      t[4]  = mk(4'b0100, 4'b0, HTRANS_BUSY,   HBURST_INCR4,  1'b1, ex(4'b0010, 1, 1'b0, 1, ARB_BURST));
      t[5]  = mk(4'b0100, 4'b0, HTRANS_SEQ,    HBURST_INCR4,  1'b0, ex(4'b0010, 1, 1'b0, 1, ARB_BURST));
      t[6]  = mk(4'b0100, 4'b0, HTRANS_SEQ,    HBURST_INCR4,  1'b0, ex(4'b0010, 1, 1'b0, 1, ARB_BURST));
      t[7]  = mk(4'b0100, 4'b0, HTRANS_SEQ,    HBURST_INCR4,  1'b1, ex(4'b0010, 1, 1'b0, 1, ARB_BURST));
      t[8]  = mk(4'b0100, 4'b0, HTRANS_SEQ,    HBURST_INCR4,  1'b1, ex(4'b0010, 1, 1'b0, 1, ARB_OWN));
      t[9]  = mk(4'b0100, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b0100, 1, 1'b0, 1, ARB_OWN));
      t[10] = mk(4'b0100, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b0100, 2, 1'b0, 1, ARB_OWN));
      t[11] = mk(4'b0000, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b0001, 2, 1'b0, 2, ARB_IDLE));
      t[12] = mk(4'b0000, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b0001, 0, 1'b0, 2, ARB_IDLE));
      for (int i = 0; i < 13; i++) begin
         exp_q.push_back(t[i].exp);
         drive(t[i]);
         got = observe();
         want = exp_q.pop_front();
         vectors++;
         if (got !== want) begin
            errors++;
            $display("FAIL burst[%0d]: got %h expected %h", i, got, want);
         end
      end
   endtask

   // Master 3 locked through SINGLE transfers while master 0 requests.
   task automatic test_lock();
      step_t t [10];
      logic [12:0] want;
      logic [12:0] got;
      t[0] = mk(4'b1000, 4'b1000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b1000, 0, 1'b0, 0, ARB_OWN));
      t[1] = mk(4'b1001, 4'b1000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b1000, 3, 1'b1, 0, ARB_LOCKED));
      t[2] = mk(4'b1001, 4'b1000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, ex(4'b1000, 3, 1'b1, 3, ARB_LOCKED));
      t[3] = mk(4'b1001, 4'b1000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, ex(4'b1000, 3, 1'b1, 3, ARB_LOCKED));
      t[4] = mk(4'b1001, 4'b1000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, ex(4'b1000, 3, 1'b1, 3, ARB_LOCKED));
      t[5] = mk(4'b1001, 4'b1000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, ex(4'b1000, 3, 1'b1, 3, ARB_LOCKED));
      t[6] = mk(4'b1001, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b1000, 3, 1'b0, 3, ARB_OWN));
      t[7] = mk(4'b1001, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b0001, 3, 1'b0, 3, ARB_OWN));
      t[8] = mk(4'b0001, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b0001, 0, 1'b0, 3, ARB_OWN));
      t[9] = mk(4'b0000, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b0001, 0, 1'b0, 0, ARB_IDLE));
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back(t[i].exp);
         drive(t[i]);
         got = observe();
         want = exp_q.pop_front();
         vectors++;
         if (got !== want) begin
            errors++;
            $display("FAIL lock[%0d]: got %h expected %h", i, got, want);
         end
      end
   endtask

   // Master 2 WRAP8 cut short by IDLE after two beats; master 1 then takes the bus.
   task automatic test_early_term();
      step_t t [8];
      logic [12:0] want;
      logic [12:0] got;
      t[0] = mk(4'b0100, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b0100, 0, 1'b0, 0, ARB_OWN));
      t[1] = mk(4'b0100, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b0100, 2, 1'b0, 0, ARB_OWN));
      t[2] = mk(4'b0110, 4'b0, HTRANS_NONSEQ, HBURST_WRAP8,  1'b1, ex(4'b0100, 2, 1'b0, 2, ARB_BURST));
      t[3] = mk(4'b0010, 4'b0, HTRANS_SEQ,    HBURST_WRAP8,  1'b1, ex(4'b0100, 2, 1'b0, 2, ARB_BURST));
      t[4] = mk(4'b0010, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b0100, 2, 1'b0, 2, ARB_OWN));
      t[5] = mk(4'b0010, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b0010, 2, 1'b0, 2, ARB_OWN));
      t[6] = mk(4'b0000, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b0001, 1, 1'b0, 2, ARB_IDLE));
      t[7] = mk(4'b0000, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b0001, 0, 1'b0, 1, ARB_IDLE));
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(t[i].exp);
         drive(t[i]);
         got = observe();
         want = exp_q.pop_front();
         vectors++;
         if (got !== want) begin
            errors++;
            $display("FAIL early_term[%0d]: got %h expected %h", i, got, want);
         end
      end
   endtask

   // Reset asserted between clock edges in the middle of an INCR16 burst.
   task automatic test_async_reset();
      step_t t [5];
      logic [12:0] want;
      logic [12:0] got;
      t[0] = mk(4'b0010, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b0010, 0, 1'b0, 0, ARB_OWN));
      t[1] = mk(4'b0010, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, ex(4'b0010, 1, 1'b0, 0, ARB_OWN));
      t[2] = mk(4'b0110, 4'b0, HTRANS_NONSEQ, HBURST_INCR16, 1'b1, ex(4'b0010, 1, 1'b0, 1, ARB_BURST));
      t[3] = mk(4'b0100, 4'b0, HTRANS_SEQ,    HBURST_INCR16, 1'b1, ex(4'b0010, 1, 1'b0, 1, ARB_BURST));
      t[4] = mk(4'b0100, 4'b0, HTRANS_SEQ,    HBURST_INCR16, 1'b1, ex(4'b0100, 0, 1'b0, 0, ARB_OWN));
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(t[i].exp);
         drive(t[i]);
         got = observe();
         want = exp_q.pop_front();
         vectors++;
         if (got !== want) begin
            errors++;
            $display("FAIL async_reset[%0d]: got %h expected %h", i, got, want);
         end
      end
      // no clock edge between asserting reset and sampling
      exp_q.push_back(ex(4'b0001, 0, 1'b0, 0, ARB_IDLE));
      #2 ahb_rstn_in = 1'b0;
      #1;
      got = observe();
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
         errors++;
         $display("FAIL async_reset_mid: got %h expected %h", got, want);
      end
      @(posedge ahb_clk_in);
      #3 ahb_rstn_in = 1'b1;
      // the interrupted burst must not hold the grant after reset
      exp_q.push_back(t[4].exp);
      drive(t[4]);
      got = observe();
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
         errors++;
         $display("FAIL async_reset_after: got %h expected %h", got, want);
      end
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      test_reset();
      test_simultaneous();
      test_burst();
      test_lock();
      test_early_term();
      test_async_reset();
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
